mitm_rule_engine: RTL and testbench

Programmable byte-rewrite stage between the SPI read buffers and the serial write buffers of the MITM datapath. On each `eval` pulse it latches the captured MISO/MOSI bytes and scans a small rule table in priority order. It then returns replacement bytes and per-line fake-select flags, with a one-cycle `data_valid` pulse. The control FSM starts the write phase on that pulse.

---
 rtl/mitm_pkg.sv | 15 +
 rtl/mitm_rule_table.sv | 26 ++
 rtl/mitm_rule_engine.sv | 122 ++++++++++++
 tb/tb_mitm_rule_engine.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mitm_pkg.sv
// mitm_pkg: shared FSM encoding, rule flag bit positions and rule record width
// Holds the FSM state encoding, the cfg_flags bit positions and the rule record width.
package mitm_pkg;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  localparam int FLAG_EN         = 0;
  localparam int FLAG_REPL_MISO  = 1;
  localparam int FLAG_REPL_MOSI  = 2;
  localparam int FLAG_MATCH_MISO = 3;
  localparam int FLAG_IDX_QUAL   = 4;
  localparam int FLAG_W          = 5;
  // A rule record is {match, mask, repl_miso, repl_mosi, index, flags}.
  function automatic int rule_w(input int dw, input int iw);
    return 4 * dw + iw + FLAG_W;
  endfunction
endpackage

// File: rtl/mitm_rule_table.sv
// mitm_rule_table: rule register file, synchronous write and combinational read
// Ports:
//   sys_clk, rst_n    clock and asynchronous active-low reset (clears every entry)
//   we, waddr, wdata  write strobe, entry index and record to store
//   raddr, rdata      read index and combinational record output
module mitm_rule_table #(
  parameter int NUM_RULES = 8,
  parameter int RULE_W    = 41
) (
  input  logic                         sys_clk,
  input  logic                         rst_n,
  input  logic                         we,
  input  logic [$clog2(NUM_RULES)-1:0] waddr,
  input  logic [RULE_W-1:0]            wdata,
  input  logic [$clog2(NUM_RULES)-1:0] raddr,
  output logic [RULE_W-1:0]            rdata
);
  logic [RULE_W-1:0] r_mem [NUM_RULES];
  always_ff @(posedge sys_clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < NUM_RULES; i++) r_mem[i] <= '0;
    end else if (we) begin
      r_mem[waddr] <= wdata;
    end
  assign rdata = r_mem[raddr];
endmodule

// File: rtl/mitm_rule_engine.sv
// mitm_rule_engine: priority-ordered byte-rewrite stage for the MITM SPI datapath
// Ports:
//   sys_clk, rst_n                    clock, asynchronous active-low reset
//   frame_start                       clears the byte index (SS start)
//   eval, real_miso_data/mosi_data    evaluate request and captured bytes
//   cfg_*                             rule table write port
//   fake_*_data, fake_*_select        rewritten bytes and fake-line selects
//   data_valid, busy                  one-cycle result pulse, engine occupied
//   hit_count                         matched-byte counter, only with MITM_HIT_COUNTER_EN
module mitm_rule_engine
  import mitm_pkg::*;
#(
  parameter int DATA_SIZE = 8,
  parameter int NUM_RULES = 8,
  parameter int IDX_W     = 4
) (
  input  logic                         sys_clk,
  input  logic                         rst_n,
  input  logic                         frame_start,
  input  logic                         eval,
  input  logic [DATA_SIZE-1:0]         real_miso_data,
  input  logic [DATA_SIZE-1:0]         real_mosi_data,
  input  logic                         cfg_we,
  input  logic [$clog2(NUM_RULES)-1:0] cfg_addr,
  input  logic [DATA_SIZE-1:0]         cfg_match,
  input  logic [DATA_SIZE-1:0]         cfg_mask,
  input  logic [DATA_SIZE-1:0]         cfg_repl_miso,
  input  logic [DATA_SIZE-1:0]         cfg_repl_mosi,
  input  logic [IDX_W-1:0]             cfg_index,
  input  logic [FLAG_W-1:0]            cfg_flags,
  output logic [DATA_SIZE-1:0]         fake_miso_data,
  output logic [DATA_SIZE-1:0]         fake_mosi_data,
  output logic                         fake_miso_select,
  output logic                         fake_mosi_select,
  output logic                         data_valid,
  output logic                         busy
`ifdef MITM_HIT_COUNTER_EN
  ,
  output logic [15:0]                  hit_count
`endif
);
  localparam int AW = $clog2(NUM_RULES);
  localparam int RW = rule_w(DATA_SIZE, IDX_W);
  state_t                 r_state, w_next;
  logic [AW-1:0]          r_ptr;
  logic [DATA_SIZE-1:0]   r_miso, r_mosi;
  logic [IDX_W-1:0]       r_idx, r_idx_lat;
  logic                   r_fs_hold;
  logic [RW-1:0]          w_rule;
  logic [DATA_SIZE-1:0]   w_match, w_mask, w_rmiso, w_rmosi, w_sel;
  logic [IDX_W-1:0]       w_ridx;
  logic [FLAG_W-1:0]      w_flags;
  logic                   w_hit, w_last, w_scan_end;
  mitm_rule_table #(.NUM_RULES(NUM_RULES), .RULE_W(RW)) u_table (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .we      (cfg_we),
    .waddr   (cfg_addr),
    .wdata   ({cfg_match, cfg_mask, cfg_repl_miso, cfg_repl_mosi, cfg_index, cfg_flags}),
    .raddr   (r_ptr),
    .rdata   (w_rule)
  );
  assign {w_match, w_mask, w_rmiso, w_rmosi, w_ridx, w_flags} = w_rule;
  assign w_sel      = w_flags[FLAG_MATCH_MISO] ? r_miso : r_mosi;
  assign w_hit      = w_flags[FLAG_EN] && ((w_sel ^ w_match) & w_mask) == '0 &&
                      (!w_flags[FLAG_IDX_QUAL] || r_idx_lat == w_ridx);
  assign w_last     = r_ptr == AW'(NUM_RULES - 1);
  assign w_scan_end = r_state == SCAN && (w_hit || w_last);
  assign data_valid = r_state == DONE;
  assign busy       = r_state != IDLE;
  always_ff @(posedge sys_clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  always_comb begin
    w_next = r_state;
    w_next = r_state == IDLE ? (eval ? SCAN : IDLE) :
             r_state == SCAN ? ((w_hit || w_last) ? DONE : SCAN) : IDLE;
  end
  always_ff @(posedge sys_clk or negedge rst_n)
    if (!rst_n) begin
      r_ptr            <= '0;
      r_miso           <= '0;
      r_mosi           <= '0;
      r_idx            <= '0;
      r_idx_lat        <= '0;
      r_fs_hold        <= 1'b0;
      fake_miso_data   <= '0;
      fake_mosi_data   <= '0;
      fake_miso_select <= 1'b0;
      fake_mosi_select <= 1'b0;
    end else begin
      if (r_state == IDLE && eval) begin
        r_miso    <= real_miso_data;
        r_mosi    <= real_mosi_data;
        r_idx_lat <= frame_start ? '0 : r_idx;
        r_ptr     <= '0;
      end
      if (r_state == SCAN) r_ptr <= r_ptr + 1'b1;
      if (w_scan_end) begin
        fake_miso_data   <= (w_hit && w_flags[FLAG_REPL_MISO]) ? w_rmiso : r_miso;
        fake_mosi_data   <= (w_hit && w_flags[FLAG_REPL_MOSI]) ? w_rmosi : r_mosi;
        fake_miso_select <= w_hit && w_flags[FLAG_REPL_MISO];
        fake_mosi_select <= w_hit && w_flags[FLAG_REPL_MOSI];
      end
      // A frame_start seen during SCAN must keep the index at 0 through DONE.
      if (frame_start) r_idx <= '0;
      else if (r_state == DONE && !r_fs_hold) r_idx <= (r_idx == '1) ? r_idx : r_idx + 1'b1;
      if (r_state == DONE) r_fs_hold <= 1'b0;
      else if (frame_start && r_state == SCAN) r_fs_hold <= 1'b1;
    end
`ifdef MITM_HIT_COUNTER_EN
  logic r_matched;
  always_ff @(posedge sys_clk or negedge rst_n)
    if (!rst_n) begin
      r_matched <= 1'b0;
      hit_count <= '0;
    end else begin
      if (w_scan_end) r_matched <= w_hit;
      if (r_state == DONE && r_matched && hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
    end
`endif
endmodule

// File: tb/tb_mitm_rule_engine.sv
// tb_mitm_rule_engine: directed self-checking bench for mitm_rule_engine
module tb_mitm_rule_engine;
  logic       sys_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_start = 1'b0;
  logic       eval = 1'b0;
  logic [7:0] real_miso_data = '0, real_mosi_data = '0;
  logic       cfg_we = 1'b0;
  logic [2:0] cfg_addr = '0;
  logic [7:0] cfg_match = '0, cfg_mask = '0, cfg_repl_miso = '0, cfg_repl_mosi = '0;
  logic [3:0] cfg_index = '0;
  logic [4:0] cfg_flags = '0;
  logic [7:0] fake_miso_data, fake_mosi_data;
  logic       fake_miso_select, fake_mosi_select, data_valid, busy;
`ifdef MITM_HIT_COUNTER_EN
  logic [15:0] hit_count;
`endif
  int checks = 0;
  int errors = 0;

  always #5 sys_clk = ~sys_clk;

  mitm_rule_engine dut (
    .sys_clk          (sys_clk),
    .rst_n            (rst_n),
    .frame_start      (frame_start),
    .eval             (eval),
    .real_miso_data   (real_miso_data),
    .real_mosi_data   (real_mosi_data),
    .cfg_we           (cfg_we),
    .cfg_addr         (cfg_addr),
    .cfg_match        (cfg_match),
    .cfg_mask         (cfg_mask),
    .cfg_repl_miso    (cfg_repl_miso),
    .cfg_repl_mosi    (cfg_repl_mosi),
    .cfg_index        (cfg_index),
    .cfg_flags        (cfg_flags),
    .fake_miso_data   (fake_miso_data),
    .fake_mosi_data   (fake_mosi_data),
    .fake_miso_select (fake_miso_select),
    .fake_mosi_select (fake_mosi_select),
    .data_valid       (data_valid),
    .busy             (busy)
`ifdef MITM_HIT_COUNTER_EN
    ,
    .hit_count        (hit_count)
`endif
  );

  task automatic do_reset();
    @(negedge sys_clk);
    rst_n = 1'b0;
    repeat (2) @(negedge sys_clk);
    rst_n = 1'b1;
  endtask

  task automatic write_rule(input logic [2:0] a, input logic [7:0] m, k, rmi, rmo,
                            input logic [3:0] ix, input logic [4:0] fl);
    @(negedge sys_clk);
    cfg_we = 1'b1; cfg_addr = a; cfg_match = m; cfg_mask = k;
    cfg_repl_miso = rmi; cfg_repl_mosi = rmo; cfg_index = ix; cfg_flags = fl;
    @(negedge sys_clk);
    cfg_we = 1'b0;
  endtask

  // lat is the cycle number (eval cycle = 0) in which data_valid is seen; 40 means it never came.
  task automatic run_eval(input logic [7:0] mi, mo, input logic fs, input int fs_at, output int lat);
    @(negedge sys_clk);
    real_miso_data = mi; real_mosi_data = mo; eval = 1'b1; frame_start = fs;
    @(negedge sys_clk);
    eval = 1'b0; frame_start = 1'b0; lat = 1;
    while (data_valid !== 1'b1 && lat < 40) begin
      if (lat == fs_at) frame_start = 1'b1;
      @(negedge sys_clk);
      frame_start = 1'b0;
      lat++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({fake_miso_data, fake_mosi_data} !== 16'h0000) begin
      errors++; $display("FAIL reset_data got %h expected 0000", {fake_miso_data, fake_mosi_data});
    end
    checks++;
    if ({fake_miso_select, fake_mosi_select, data_valid, busy} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl got %b expected 0000",
                         {fake_miso_select, fake_mosi_select, data_valid, busy});
    end
  endtask

  task automatic test_empty();
    int lat;
    do_reset();
    run_eval(8'h3C, 8'hA5, 1'b0, 0, lat);
    checks++;
    if (lat !== 9) begin errors++; $display("FAIL empty_latency got %0d expected 9", lat); end
    checks++;
    if ({fake_miso_data, fake_mosi_data, fake_miso_select, fake_mosi_select} !== {8'h3C, 8'hA5, 2'b00}) begin
      errors++; $display("FAIL empty_out got %h %h %b%b expected 3c a5 00",
                         fake_miso_data, fake_mosi_data, fake_miso_select, fake_mosi_select);
    end
  endtask

  task automatic test_single_rule();
    int lat;
    do_reset();
    write_rule(3'd2, 8'hA0, 8'hF0, 8'h55, 8'h00, 4'd0, 5'b00011);
    run_eval(8'h12, 8'hA7, 1'b0, 0, lat);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL single_latency got %0d expected 4", lat); end
    checks++;
    if ({fake_miso_data, fake_mosi_data, fake_miso_select, fake_mosi_select} !== {8'h55, 8'hA7, 2'b10}) begin
      errors++; $display("FAIL single_out got %h %h %b%b expected 55 a7 10",
                         fake_miso_data, fake_mosi_data, fake_miso_select, fake_mosi_select);
    end
    @(negedge sys_clk);
    checks++;
    if ({data_valid, busy} !== 2'b00) begin
      errors++; $display("FAIL single_after got dv/busy %b expected 00", {data_valid, busy});
    end
    checks++;
    if (fake_miso_data !== 8'h55 || fake_miso_select !== 1'b1) begin
      errors++; $display("FAIL single_hold got %h/%b expected 55/1", fake_miso_data, fake_miso_select);
    end
  endtask

  task automatic test_priority();
    int lat;
    do_reset();
    write_rule(3'd1, 8'h10, 8'hFF, 8'h00, 8'h11, 4'd0, 5'b00101);
    write_rule(3'd3, 8'h10, 8'hFF, 8'h00, 8'h33, 4'd0, 5'b00101);
    run_eval(8'h9E, 8'h10, 1'b0, 0, lat);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL prio_latency got %0d expected 3", lat); end
    checks++;
    if ({fake_miso_data, fake_mosi_data, fake_miso_select, fake_mosi_select} !== {8'h9E, 8'h11, 2'b01}) begin
      errors++; $display("FAIL prio_out got %h %h %b%b expected 9e 11 01",
                         fake_miso_data, fake_mosi_data, fake_miso_select, fake_mosi_select);
    end
  endtask

  task automatic test_index();
    int lat;
    logic [7:0] exp_mosi [6] = '{8'h00, 8'h00, 8'h77, 8'h00, 8'h00, 8'h77};
    do_reset();
    write_rule(3'd0, 8'h00, 8'hFF, 8'h00, 8'h77, 4'd2, 5'b10101);
    for (int i = 0; i < 6; i++) begin
      run_eval(8'h00, 8'h00, (i == 0 || i == 3), 0, lat);
      checks++;
      if (fake_mosi_data !== exp_mosi[i] || fake_mosi_select !== (exp_mosi[i] == 8'h77)) begin
        errors++; $display("FAIL index_byte%0d got %h/%b expected %h", i, fake_mosi_data, fake_mosi_select, exp_mosi[i]);
      end
    end
    // Index is now 3; a frame_start during SCAN must leave the next byte at index 0.
    write_rule(3'd0, 8'h00, 8'hFF, 8'h00, 8'h77, 4'd0, 5'b10101);
    run_eval(8'h00, 8'h00, 1'b0, 2, lat);
    checks++;
    if (fake_mosi_select !== 1'b0) begin
      errors++; $display("FAIL index_midscan got sel %b expected 0", fake_mosi_select);
    end
    run_eval(8'h00, 8'h00, 1'b0, 0, lat);
    checks++;
    if (lat !== 2 || fake_mosi_data !== 8'h77) begin
      errors++; $display("FAIL index_suppress got lat %0d data %h expected 2 77", lat, fake_mosi_data);
    end
  endtask

  task automatic test_busy();
    int dv_cnt = 0;
    int busy_c1 = 0;
    do_reset();
    @(negedge sys_clk);
    real_miso_data = 8'h01; real_mosi_data = 8'h02; eval = 1'b1;
    for (int c = 1; c < 25; c++) begin
      @(negedge sys_clk);
      eval = (c == 3);
      if (c == 1) busy_c1 = busy;
      dv_cnt += data_valid;
    end
    checks++;
    if (busy_c1 !== 1) begin errors++; $display("FAIL busy_rise got %0d expected 1", busy_c1); end
    checks++;
    if (dv_cnt !== 1) begin errors++; $display("FAIL busy_ignore got %0d pulses expected 1", dv_cnt); end
  endtask

  task automatic test_reset_midscan();
    int lat;
    int dv_cnt = 0;
    do_reset();
    write_rule(3'd7, 8'h00, 8'h00, 8'hEE, 8'hDD, 4'd0, 5'b00111);
    @(negedge sys_clk);
    real_miso_data = 8'h44; real_mosi_data = 8'h66; eval = 1'b1;
    repeat (4) begin @(negedge sys_clk); eval = 1'b0; end
    rst_n = 1'b0;
    repeat (2) begin @(negedge sys_clk); dv_cnt += data_valid; end
    rst_n = 1'b1;
    repeat (12) begin @(negedge sys_clk); dv_cnt += data_valid; end
    checks++;
    if (dv_cnt !== 0) begin errors++; $display("FAIL midrst_dv got %0d pulses expected 0", dv_cnt); end
    checks++;
    if ({fake_miso_data, fake_mosi_data, fake_miso_select, fake_mosi_select, busy} !== 19'h0) begin
      errors++; $display("FAIL midrst_out got %h %h %b%b busy %b expected zeros",
                         fake_miso_data, fake_mosi_data, fake_miso_select, fake_mosi_select, busy);
    end
    run_eval(8'h44, 8'h66, 1'b0, 0, lat);
    checks++;
    if (lat !== 9 || {fake_miso_data, fake_mosi_data, fake_miso_select, fake_mosi_select} !== {8'h44, 8'h66, 2'b00}) begin
      errors++; $display("FAIL midrst_cleared got lat %0d %h %h %b%b expected 9 44 66 00",
                         lat, fake_miso_data, fake_mosi_data, fake_miso_select, fake_mosi_select);
    end
  endtask

`ifdef MITM_HIT_COUNTER_EN
  task automatic test_hit_counter();
    int lat;
    logic [7:0] mo [5] = '{8'h10, 8'h20, 8'h10, 8'h20, 8'h10};
    do_reset();
    write_rule(3'd0, 8'h10, 8'hFF, 8'h00, 8'h99, 4'd0, 5'b00101);
    for (int i = 0; i < 5; i++) run_eval(8'h00, mo[i], 1'b0, 0, lat);
    @(negedge sys_clk);
    checks++;
    if (hit_count !== 16'd3) begin errors++; $display("FAIL hit_count got %0d expected 3", hit_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_empty();
    test_single_rule();
    test_priority();
    test_index();
    test_busy();
    test_reset_midscan();
`ifdef MITM_HIT_COUNTER_EN
    test_hit_counter();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
